aer_depacketizer: RTL
=====================

# aer_depacketizer

Receiver end of the AER link in the speech front-end. It accepts 16-bit address-event words from the AER packetizer over a synchronous four-phase req/ack handshake, checks parity, and rebuilds absolute spike timestamps from per-word time deltas. Decoded events are buffered in an internal FIFO and handed to the window accumulator over a valid/ready interface.

## Interface
- `FIFO_DEPTH`, 16, event FIFO depth; power of two, ≥2.
- `TS_W`, 24, absolute timestamp width; ≥11.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `aer_req` in 1: packetizer request; four-phase.
- `aer_data` in 16: word = {parity[15], channel[14:10], delta[9:0]}; stable while `aer_req`=1.
- `aer_ack` out 1: acknowledge.
- `evt_valid` out 1: FIFO head valid.
- `evt_ready` in 1: consumer accepts head.
- `evt_channel` out 5: head channel.
- `evt_time` out TS_W: head absolute timestamp.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `parity_err_cnt` out 8: saturating count of rejected words.

## Operation
- Word format:
  - Even parity: XOR of all 16 bits must be 0, otherwise the word is a parity error.
  - Channel 31 is the time marker. It carries time and never produces an event.
  - Channels 0–30 are spikes.
- Handshake FSM, three states:
  - SYNC (reset state): wait for `aer_req`=0, then go to IDLE. This guarantees a request already high at reset release is never decoded.
  - IDLE: when `aer_req`=1 and the word can be accepted, capture `aer_data`, process it, set `aer_ack`=1, and go to ACK. A spike word can be accepted only when `fifo_level`<FIFO_DEPTH. A marker or parity-error word can always be accepted.
  - IDLE with `aer_req`=1 and a good spike word while the FIFO is full: stay in IDLE with `aer_ack`=0 (backpressure). The word is re-evaluated every cycle.
  - ACK: hold `aer_ack`=1 until `aer_req`=0 is sampled, then drive `aer_ack`=0 and go to IDLE.
- Processing a good word:
  - Update `abs_time` ← `abs_time` + delta, modulo 2^TS_W.
  - For a spike, push {channel, updated `abs_time`} to the FIFO.
  - For a marker, update time only.
- Parity-error word:
  - Acknowledged normally.
  - `abs_time` is unchanged and nothing is pushed.
  - `parity_err_cnt` increments, saturating at 255.
- FIFO behaviour:
  - Show-ahead: `evt_valid` = (`fifo_level`≠0), and `evt_channel`/`evt_time` reflect the head.
  - A pop occurs on `evt_valid`&`evt_ready`.
  - Push and pop in the same cycle leave `fifo_level` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (asynchronous) clears immediately: `aer_ack`=0, `evt_valid`=0, `evt_channel`=0, `evt_time`=0, `fifo_level`=0, `parity_err_cnt`=0, `abs_time`=0, FSM=SYNC. FIFO contents are discarded.

## Timing
- Ack latency: `aer_req` sampled high in IDLE (acceptable word) gives `aer_ack`=1 after the same edge, i.e. 1 cycle.
- Ack release: `aer_req` sampled low in ACK gives `aer_ack`=0 after that edge.
- Minimum handshake: 4 cycles per word (IDLE sample, ACK, req low seen, IDLE).
- Event latency: the event becomes visible at the FIFO head on the cycle after capture. `evt_valid` rises on the same edge that raises `aer_ack`, when the FIFO was empty.
- Full-FIFO boundary: a pop in the same cycle does not permit acceptance. The full check uses the registered `fifo_level`, so `aer_ack` rises one cycle after the level drops below FIFO_DEPTH.
- `fifo_level` and `parity_err_cnt` are registered and update on the same edge as the corresponding push, pop, or capture.

## Test plan
- Single spike: reset, then send 0x0C05 → `aer_ack` 1 cycle after req; event ch=3, time=5; `fifo_level`=1; pop with `evt_ready`=1 → `evt_valid`=0.
- Marker accumulation: send 0x0C05, 0xFFFF, 0x8001 → exactly two events: (ch3, t=5), (ch0, t=1029); no event for the marker.
- Parity error: send 0x0C04 → acked, no event, `parity_err_cnt`=1, `abs_time` unchanged (next 0x8001 yields t=1). Send 256 bad words → count saturates at 255.
- Backpressure: `evt_ready`=0, send 16 spikes → `fifo_level`=16. The 17th req stays unacked indefinitely. Pulse one pop → ack follows, level returns to 16, and the FIFO order and timestamps stay intact.
- Reset mid-handshake: assert `rst` during ACK with `aer_req`=1 → `aer_ack`=0 immediately. Release `rst` with req still high → no ack and no event until req falls. The next word decodes with time = its own delta.
- Timestamp wrap: TS_W=11, send two markers 0xFFFF then 0x8001 → event ch0, t=(1023+1023+1) mod 2048=2047. One more 0x8001 → t=0.

Source files
------------

// File: rtl/aer_depacketizer_if.sv
// AER receive bundle: packetizer-side four-phase req/ack word link plus the
// show-ahead valid/ready event stream toward the window accumulator.
interface aer_depacketizer_if #(
  parameter int TS_W = 24
);
  logic            aer_req;
  logic [15:0]     aer_data;
  logic            aer_ack;
  logic            evt_valid;
  logic            evt_ready;
  logic [4:0]      evt_channel;
  logic [TS_W-1:0] evt_time;

  modport master (
    output aer_req, aer_data, evt_ready,
    input  aer_ack, evt_valid, evt_channel, evt_time
  );

  modport slave (
    input  aer_req, aer_data, evt_ready,
    output aer_ack, evt_valid, evt_channel, evt_time
  );
endinterface

// File: rtl/aer_depacketizer.sv
// AER word receiver: parity check, delta-to-absolute timestamp rebuild and a
// show-ahead event FIFO behind a four-phase req/ack handshake.
module aer_depacketizer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  aer_depacketizer_if.slave           bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  parity_err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {SYNC, IDLE, ACK} state_t;

  state_t          state, state_nxt;
  logic            parity_ok, is_marker, can_accept;
  logic            capture, push, pop;
  logic [4:0]      word_ch;
  logic [TS_W-1:0] abs_time, time_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      mem_ch [FIFO_DEPTH];
  logic [TS_W-1:0] mem_ts [FIFO_DEPTH];

  assign word_ch    = bus.aer_data[14:10];
  assign parity_ok  = ~(^bus.aer_data);
  assign is_marker  = (word_ch == 5'd31);
  // Only good spikes need FIFO room; markers and bad words are always taken.
  assign can_accept = !parity_ok || is_marker || (fifo_level < LW'(FIFO_DEPTH));
  assign time_nxt   = abs_time + {{(TS_W-10){1'b0}}, bus.aer_data[9:0]};
  assign push       = capture && parity_ok && !is_marker;
  assign pop        = bus.evt_valid && bus.evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      SYNC: if (!bus.aer_req) state_nxt = IDLE;
      IDLE: if (bus.aer_req && can_accept) begin
        capture   = 1'b1;
        state_nxt = ACK;
      end
      ACK:  if (!bus.aer_req) state_nxt = IDLE;
      default: state_nxt = SYNC;
    endcase
  end

  assign bus.aer_ack = (state == ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_time       <= '0;
      parity_err_cnt <= '0;
    end else if (capture) begin
      if (parity_ok)                     abs_time       <= time_nxt;
      else if (parity_err_cnt != 8'hFF)  parity_err_cnt <= parity_err_cnt + 8'd1;
    end
  end

  // Storage is not reset; emptiness is tracked by the level and pointers only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ch[wr_ptr] <= word_ch;
      mem_ts[wr_ptr] <= time_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign bus.evt_valid   = (fifo_level != '0);
  assign bus.evt_channel = bus.evt_valid ? mem_ch[rd_ptr] : 5'd0;
  assign bus.evt_time    = bus.evt_valid ? mem_ts[rd_ptr] : '0;
endmodule
